// File: rtl/error_combiner_pkg.sv
// error_combiner_pkg: widths, tree depth and saturation bounds shared by the error combiner.
package error_combiner_pkg;
  function automatic int tree_depth(input int n);
    return (n <= 1) ? 0 : $clog2(n);
  endfunction
  function automatic int prod_width(input int ew, input int ww);
    return ew + ww;
  endfunction
  function automatic int sum_width(input int ew, input int ww, input int n);
    return ew + ww + tree_depth(n);
  endfunction
  function automatic int level_count(input int n, input int l);
    return (n + (1 << l) - 1) >> l;
  endfunction
  function automatic longint sat_max(input int ew);
    return (longint'(1) << (ew - 1)) - 1;
  endfunction
  function automatic longint sat_min(input int ew);
    return -(longint'(1) << (ew - 1));
  endfunction
endpackage

// File: rtl/error_combiner_sat.sv
// error_combiner_sat: round/shift/clamp of the tree sum; ERROR_COMBINER_ROUND_EN selects round-half-up over floor.
module error_combiner_sat import error_combiner_pkg::*; #(
  parameter int SUM_WIDTH   = 11,
  parameter int ERROR_WIDTH = 5,
  parameter int WEIGHT_FRAC = 2
) (
  input  logic signed [SUM_WIDTH-1:0]   sum_i,
  output logic signed [ERROR_WIDTH-1:0] err_o,
  output logic                          sat_o
);
`ifdef ERROR_COMBINER_ROUND_EN
  localparam logic signed [SUM_WIDTH:0] HALF = (WEIGHT_FRAC == 0) ? '0 :
    (SUM_WIDTH+1)'(1) << ((WEIGHT_FRAC == 0) ? 0 : WEIGHT_FRAC - 1);
`else
  localparam logic signed [SUM_WIDTH:0] HALF = '0;
`endif
  localparam logic signed [SUM_WIDTH:0] MAXV = (SUM_WIDTH+1)'(sat_max(ERROR_WIDTH));
  localparam logic signed [SUM_WIDTH:0] MINV = (SUM_WIDTH+1)'(sat_min(ERROR_WIDTH));
  logic signed [SUM_WIDTH:0] ext, sh;
  logic hi, lo;
  always_comb begin
    ext = {sum_i[SUM_WIDTH-1], sum_i} + HALF;
    sh = ext >>> WEIGHT_FRAC;
    hi = sh > MAXV;
    lo = sh < MINV;
    sat_o = hi | lo;
    err_o = hi ? MAXV[ERROR_WIDTH-1:0] : lo ? MINV[ERROR_WIDTH-1:0] : sh[ERROR_WIDTH-1:0];
  end
endmodule

// File: rtl/error_combiner_pipe.sv
// error_combiner_pipe: pipelined weighted error combiner with shadowed weights, tree sum and saturation.
// Build option: ERROR_COMBINER_ROUND_EN enables round-half-up (default floor).
module error_combiner_pipe import error_combiner_pkg::*; #(
  parameter int NUM_CH       = 4,
  parameter int WEIGHT_WIDTH = 4,
  parameter int ERROR_WIDTH  = 5,
  parameter int WEIGHT_FRAC  = 2
) (
  input  logic                             clk_i,
  input  logic                             reset_i,
  input  logic                             weight_load_i,
  input  logic [NUM_CH*WEIGHT_WIDTH-1:0]   weights_i,
  input  logic                             valid_i,
  input  logic [NUM_CH*ERROR_WIDTH-1:0]    errors_i,
  output logic                             valid_o,
  output logic signed [ERROR_WIDTH-1:0]    error_comb_o,
  output logic                             sat_o
);
  localparam int T  = tree_depth(NUM_CH);
  localparam int PW = prod_width(ERROR_WIDTH, WEIGHT_WIDTH);
  localparam int SW = sum_width(ERROR_WIDTH, WEIGHT_WIDTH, NUM_CH);
  localparam logic [NUM_CH*WEIGHT_WIDTH-1:0] W_RST = (NUM_CH*WEIGHT_WIDTH)'(1 << WEIGHT_FRAC);
  logic [NUM_CH*WEIGHT_WIDTH-1:0] w_q, w_d;
  logic [T+1:0] vld_q, vld_d;
  logic signed [SW-1:0] lvl_q [0:T][0:NUM_CH-1];
  logic signed [SW-1:0] lvl_d [0:T][0:NUM_CH-1];
  logic signed [ERROR_WIDTH-1:0] out_q, out_d, sat_val;
  logic sat_q, sat_d, sat_c;
  always_comb begin
    w_d = weight_load_i ? weights_i : w_q;
    vld_d = {vld_q[T:0], valid_i};
    out_d = vld_q[T] ? sat_val : out_q;
    sat_d = vld_q[T] ? sat_c : sat_q;
  end
  for (genvar i = 0; i < NUM_CH; i++) begin : g_mul
    logic signed [ERROR_WIDTH-1:0]  e;
    logic signed [WEIGHT_WIDTH-1:0] w;
    logic signed [PW-1:0]           p;
    assign e = errors_i[i*ERROR_WIDTH +: ERROR_WIDTH];
    assign w = w_q[i*WEIGHT_WIDTH +: WEIGHT_WIDTH];
    assign p = PW'(e) * PW'(w);
    assign lvl_d[0][i] = valid_i ? SW'(p) : lvl_q[0][i];
  end
  // Each level halves the element count; an odd tail element passes straight through.
  for (genvar l = 1; l <= T; l++) begin : g_lvl
    localparam int N = level_count(NUM_CH, l - 1);
    for (genvar i = 0; i < NUM_CH; i++) begin : g_el
      logic signed [SW-1:0] nxt;
      if (2 * i + 1 < N) begin : g_add
        assign nxt = lvl_q[l-1][2*i] + lvl_q[l-1][2*i+1];
      end else if (2 * i < N) begin : g_pass
        assign nxt = lvl_q[l-1][2*i];
      end else begin : g_zero
        assign nxt = '0;
      end
      assign lvl_d[l][i] = vld_q[l-1] ? nxt : lvl_q[l][i];
    end
  end
  error_combiner_sat #(
    .SUM_WIDTH  (SW),
    .ERROR_WIDTH(ERROR_WIDTH),
    .WEIGHT_FRAC(WEIGHT_FRAC)
  ) u_sat (
    .sum_i(lvl_q[T][0]),
    .err_o(sat_val),
    .sat_o(sat_c)
  );
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      w_q   <= W_RST;
      vld_q <= '0;
      lvl_q <= '{default: '0};
      out_q <= '0;
      sat_q <= 1'b0;
    end else begin
      w_q   <= w_d;
      vld_q <= vld_d;
      lvl_q <= lvl_d;
      out_q <= out_d;
      sat_q <= sat_d;
    end
  end
  assign valid_o      = vld_q[T+1];
  assign error_comb_o = out_q;
  assign sat_o        = sat_q;
endmodule

// File: tb/tb_error_combiner_pipe.sv
// tb_error_combiner_pipe: directed self-checking bench for error_combiner_pipe at default parameters.
module tb_error_combiner_pipe;
  logic clk = 1'b0;
  logic reset, wl, vi;
  logic [15:0] weights;
  logic [19:0] errors;
  logic valid_o, sat_o;
  logic signed [4:0] err_o;
  int n_chk = 0;
  int n_pass = 0;

  error_combiner_pipe #(
    .NUM_CH(4), .WEIGHT_WIDTH(4), .ERROR_WIDTH(5), .WEIGHT_FRAC(2)
  ) dut (
    .clk_i(clk), .reset_i(reset), .weight_load_i(wl), .weights_i(weights),
    .valid_i(vi), .errors_i(errors), .valid_o(valid_o),
    .error_comb_o(err_o), .sat_o(sat_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [19:0] pack4(input int a, input int b, input int c, input int d);
    return {5'(d), 5'(c), 5'(b), 5'(a)};
  endfunction

  task automatic load_w(input logic [15:0] w);
    weights = w;
    wl = 1'b1;
    tick();
    wl = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; wl = 1'b0; vi = 1'b0; errors = '0; weights = '0;
    tick(); tick();
    n_chk++; if (valid_o !== 1'b0) $display("FAIL reset_valid got=%b exp=0", valid_o); else n_pass++;
    n_chk++; if (err_o !== 5'sd0) $display("FAIL reset_err got=%0d exp=0", err_o); else n_pass++;
    n_chk++; if (sat_o !== 1'b0) $display("FAIL reset_sat got=%b exp=0", sat_o); else n_pass++;
    reset = 1'b0;
    errors = pack4(-16, 7, 7, 7); vi = 1'b1;
    tick(); vi = 1'b0;
    tick(); tick();
    n_chk++; if (valid_o !== 1'b0) $display("FAIL reset_early_valid got=%b exp=0", valid_o); else n_pass++;
    tick();
    n_chk++; if (valid_o !== 1'b1) $display("FAIL reset_first_valid got=%b exp=1", valid_o); else n_pass++;
    n_chk++; if (err_o !== -5'sd16) $display("FAIL reset_first_err got=%0d exp=-16", err_o); else n_pass++;
    n_chk++; if (sat_o !== 1'b0) $display("FAIL reset_first_sat got=%b exp=0", sat_o); else n_pass++;
    tick();
    n_chk++; if (valid_o !== 1'b0 || err_o !== -5'sd16)
      $display("FAIL bubble_hold got valid=%b err=%0d exp valid=0 err=-16", valid_o, err_o); else n_pass++;
  endtask

  task automatic test_stream();
    for (int c = 0; c < 36; c++) begin
      if (c < 32) begin vi = 1'b1; errors = pack4(c - 16, 0, 0, 0); end
      else vi = 1'b0;
      n_chk++;
      if (c < 4) begin
        if (valid_o !== 1'b0) $display("FAIL stream_pre c=%0d valid=%b exp=0", c, valid_o); else n_pass++;
      end else if (valid_o !== 1'b1 || err_o !== 5'(c - 20))
        $display("FAIL stream c=%0d got valid=%b err=%0d exp valid=1 err=%0d", c, valid_o, err_o, c - 20);
      else n_pass++;
      tick();
    end
    vi = 1'b0;
  endtask

  task automatic test_saturation();
    load_w(16'h4444);
    vi = 1'b1; errors = pack4(7, 7, 7, 7);
    tick(); errors = pack4(-16, -16, -16, -16);
    tick(); errors = pack4(15, 0, 0, 0);
    tick(); vi = 1'b0;
    tick();
    n_chk++; if (valid_o !== 1'b1 || err_o !== 5'sd15 || sat_o !== 1'b1)
      $display("FAIL sat_pos got v=%b err=%0d sat=%b exp v=1 err=15 sat=1", valid_o, err_o, sat_o); else n_pass++;
    tick();
    n_chk++; if (valid_o !== 1'b1 || err_o !== -5'sd16 || sat_o !== 1'b1)
      $display("FAIL sat_neg got v=%b err=%0d sat=%b exp v=1 err=-16 sat=1", valid_o, err_o, sat_o); else n_pass++;
    tick();
    n_chk++; if (valid_o !== 1'b1 || err_o !== 5'sd15 || sat_o !== 1'b0)
      $display("FAIL sat_edge got v=%b err=%0d sat=%b exp v=1 err=15 sat=0", valid_o, err_o, sat_o); else n_pass++;
  endtask

  task automatic test_rounding();
    logic signed [4:0] exp_p, exp_n;
`ifdef ERROR_COMBINER_ROUND_EN
    exp_p = 5'sd2; exp_n = -5'sd1;
`else
    exp_p = 5'sd1; exp_n = -5'sd2;
`endif
    load_w(16'h0002);
    vi = 1'b1; errors = pack4(3, 0, 0, 0);
    tick(); errors = pack4(-3, 0, 0, 0);
    tick(); vi = 1'b0;
    tick(); tick();
    n_chk++; if (valid_o !== 1'b1 || err_o !== exp_p || sat_o !== 1'b0)
      $display("FAIL round_pos got v=%b err=%0d sat=%b exp err=%0d", valid_o, err_o, sat_o, exp_p); else n_pass++;
    tick();
    n_chk++; if (valid_o !== 1'b1 || err_o !== exp_n || sat_o !== 1'b0)
      $display("FAIL round_neg got v=%b err=%0d sat=%b exp err=%0d", valid_o, err_o, sat_o, exp_n); else n_pass++;
    tick();
  endtask

  task automatic test_reload();
    load_w(16'h0004);
    for (int j = 0; j < 12; j++) begin
      if (j < 8) begin vi = 1'b1; errors = pack4(4, 0, 0, 0); end
      else vi = 1'b0;
      wl = (j == 3);
      weights = (j == 3) ? 16'h0002 : 16'h0004;
      n_chk++;
      if (j < 4) begin
        if (valid_o !== 1'b0) $display("FAIL reload_pre j=%0d valid=%b exp=0", j, valid_o); else n_pass++;
      end else if (valid_o !== 1'b1 || err_o !== ((j - 4 <= 3) ? 5'sd4 : 5'sd2))
        $display("FAIL reload sample=%0d got v=%b err=%0d exp err=%0d", j - 4, valid_o, err_o, (j - 4 <= 3) ? 4 : 2);
      else n_pass++;
      tick();
    end
    wl = 1'b0; vi = 1'b0;
  endtask

  task automatic test_reset_mid();
    vi = 1'b1; errors = pack4(8, 0, 0, 0);
    tick(); tick(); tick();
    vi = 1'b0; reset = 1'b1; wl = 1'b1; weights = 16'h0000;
    tick();
    reset = 1'b0; wl = 1'b0;
    n_chk++; if (valid_o !== 1'b0 || err_o !== 5'sd0 || sat_o !== 1'b0)
      $display("FAIL midreset_clear got v=%b err=%0d sat=%b exp v=0 err=0 sat=0", valid_o, err_o, sat_o); else n_pass++;
    for (int k = 0; k < 6; k++) begin
      tick();
      n_chk++; if (valid_o !== 1'b0) $display("FAIL midreset_stale k=%0d valid=%b exp=0", k, valid_o); else n_pass++;
    end
    vi = 1'b1; errors = pack4(5, 0, 0, 0);
    tick(); vi = 1'b0;
    tick(); tick();
    n_chk++; if (valid_o !== 1'b0) $display("FAIL midreset_early valid=%b exp=0", valid_o); else n_pass++;
    tick();
    n_chk++; if (valid_o !== 1'b1 || err_o !== 5'sd5 || sat_o !== 1'b0)
      $display("FAIL midreset_new got v=%b err=%0d sat=%b exp v=1 err=5 sat=0", valid_o, err_o, sat_o); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_saturation();
    test_rounding();
    test_reload();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
